// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: glyphs, scan states
// and the nibble decode.
package seven_seg_pkg;

    // Active-high segment patterns, a in bit 6 down to g in bit 0.
    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    return GLYPH_0;
            4'h1:    return GLYPH_1;
            4'h2:    return GLYPH_2;
            4'h3:    return GLYPH_3;
            4'h4:    return GLYPH_4;
            4'h5:    return GLYPH_5;
            4'h6:    return GLYPH_6;
            4'h7:    return GLYPH_7;
            4'h8:    return GLYPH_8;
            4'h9:    return GLYPH_9;
            4'hA:    return GLYPH_A;
            4'hB:    return GLYPH_B;
            4'hC:    return GLYPH_C;
            4'hD:    return GLYPH_D;
            4'hE:    return GLYPH_E;
            default: return GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_mux_driver_if.sv
// Datapath-to-display bundle: value/strobe inputs towards the driver, pin-level
// scan outputs back.
interface seven_seg_mux_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;

    modport master (
        output enable, load, value, dp_in, blank_in,
        input  seg, dp, an, digit_idx, frame_tick
    );

    modport slave (
        input  enable, load, value, dp_in, blank_in,
        output seg, dp, an, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg7_glyph_rom.sv
// Combinational hex nibble to active-high segment pattern.
module seg7_glyph_rom
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = hex_to_seg(nibble_i);
endmodule

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed N-digit seven-segment scanner with a frame-synchronous shadow
// buffer, guard interval, per-digit dp/blank and optional leading-zero blanking.
module seven_seg_mux_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_mux_driver_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      GUARD_CMP = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic                  SEG_INV   = (SEG_ACTIVE_LOW != 0);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] disp_val_q, sh_val_q;
    logic [NUM_DIGITS-1:0]   disp_dp_q, sh_dp_q, disp_blank_q, sh_blank_q;
    logic                    pending_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d, sel_oh, dark;
    logic [6:0]              seg_q, seg_d, glyph;
    logic                    dp_q, dp_d, frame_tick_q;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_dark, lz_run, show;

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        wrap  = 1'b0;
        if (!bus.enable || state_q == ST_OFF) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign state_d = !bus.enable ? ST_OFF : ((cnt_d < GUARD_CMP) ? ST_GUARD : ST_DRIVE);

    // A digit is leading-zero dark when it and every more-significant nibble are 0.
    always_comb begin
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        sel_oh   = '0;
        dark     = '0;
        lz_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run  = lz_run & (disp_val_q[4*i +: 4] == 4'h0);
            dark[i] = disp_blank_q[i] | ((LZ_BLANK != 0) && (i > 0) && lz_run);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_oh[i] = 1'b1;
                cur_nib   = disp_val_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_dark  = dark[i];
            end
        end
    end

    seg7_glyph_rom u_glyph_rom (
        .nibble_i (cur_nib),
        .seg_o    (glyph)
    );

    assign show  = (state_q == ST_DRIVE) && !cur_dark;
    assign an_d  = show ? (AN_OFF ^ sel_oh) : AN_OFF;
    assign seg_d = (show ? glyph : SEG_OFF) ^ {7{SEG_INV}};
    assign dp_d  = (show & cur_dp) ^ SEG_INV;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            sh_val_q     <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF ^ {7{SEG_INV}};
            dp_q         <= SEG_INV;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= wrap;
            // While dark there is nothing to tear, so loads bypass the shadow.
            if (bus.load && state_q == ST_OFF) begin
                disp_val_q   <= bus.value;
                disp_dp_q    <= bus.dp_in;
                disp_blank_q <= bus.blank_in;
            end else if (wrap) begin
                pending_q <= 1'b0;
                if (bus.load) begin
                    disp_val_q   <= bus.value;
                    disp_dp_q    <= bus.dp_in;
                    disp_blank_q <= bus.blank_in;
                    sh_val_q     <= bus.value;
                    sh_dp_q      <= bus.dp_in;
                    sh_blank_q   <= bus.blank_in;
                end else if (pending_q) begin
                    disp_val_q   <= sh_val_q;
                    disp_dp_q    <= sh_dp_q;
                    disp_blank_q <= sh_blank_q;
                end
            end else if (bus.load) begin
                sh_val_q   <= bus.value;
                sh_dp_q    <= bus.dp_in;
                sh_blank_q <= bus.blank_in;
                pending_q  <= 1'b1;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Scoreboard bench: stimulus pushes cycle-stamped expected pin states, a negedge
// monitor pops and compares them for the plain and the leading-zero-blanking DUT.
module tb_seven_seg_mux_driver;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
        logic [1:0] idx;
    } exp_t;

    localparam logic [3:0][6:0] G_12AF = {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111};
    localparam logic [3:0][6:0] G_0000 = {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};
    localparam logic [3:0][6:0] G_3456 = {7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111};
    localparam logic [3:0][6:0] G_0070 = {7'b1111110, 7'b1111110, 7'b1110000, 7'b1111110};

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t main_q[$];
    exp_t lz_q[$];

    seven_seg_mux_driver_if #(.NUM_DIGITS(4)) dif ();
    seven_seg_mux_driver_if #(.NUM_DIGITS(4)) lif ();

    assign lif.enable   = dif.enable;
    assign lif.load     = dif.load;
    assign lif.value    = dif.value;
    assign lif.dp_in    = dif.dp_in;
    assign lif.blank_in = dif.blank_in;

    seven_seg_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .LZ_BLANK(0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    seven_seg_mux_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .LZ_BLANK(1)
    ) u_dut_lz (
        .clk (clk),
        .rst (rst),
        .bus (lif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_e(input int c, input logic [3:0] an, input logic [6:0] seg,
                          input logic dp, input logic tick, input logic [1:0] idx, input bit to_lz);
        exp_t e;
        e.cyc = c; e.an = an; e.seg = seg; e.dp = dp; e.tick = tick; e.idx = idx;
        if (to_lz) lz_q.push_back(e);
        else       main_q.push_back(e);
    endtask

    // k counts edges since the enabling edge; each 4-cycle output group is one dark
    // guard cycle then three drive cycles, lagging the slot counter by one cycle.
    task automatic expect_run(input int base, input int c_from, input int c_to,
                              input logic [3:0][6:0] g, input logic [3:0] lit,
                              input logic [3:0] dpm, input bit to_lz);
        for (int c = c_from; c < c_to; c++) begin
            int k;
            int d;
            logic [3:0] an;
            logic [6:0] seg;
            logic       dp;
            k   = c - base;
            an  = 4'hF;
            seg = 7'b0;
            dp  = 1'b0;
            if (k >= 1 && ((k - 1) % 4) != 0) begin
                d = ((k - 1) / 4) % 4;
                if (lit[d]) begin
                    an[d] = 1'b0;
                    seg   = g[d];
                    dp    = dpm[d];
                end
            end
            push_e(c, an, seg, dp, (k > 0) && (k % 16 == 0), 2'((k / 4) % 4), to_lz);
        end
    endtask

    task automatic check_entry(input exp_t e, input string tag, input logic [3:0] an,
                               input logic [6:0] seg, input logic dp, input logic tick,
                               input logic [1:0] idx);
        n_checks++;
        if ({an, seg, dp, tick, idx} !== {e.an, e.seg, e.dp, e.tick, e.idx}) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got an=%b seg=%b dp=%b tick=%b idx=%0d, want an=%b seg=%b dp=%b tick=%b idx=%0d",
                     tag, e.cyc, an, seg, dp, tick, idx, e.an, e.seg, e.dp, e.tick, e.idx);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (main_q.size() > 0 && main_q[0].cyc < cyc) begin
            e = main_q.pop_front();
            n_checks++; n_errors++;
            $display("FAIL main_missed cyc=%0d: got no sample, want one at that cycle", e.cyc);
        end
        if (main_q.size() > 0 && main_q[0].cyc == cyc) begin
            e = main_q.pop_front();
            check_entry(e, "main", dif.an, dif.seg, dif.dp, dif.frame_tick, dif.digit_idx);
        end
        while (lz_q.size() > 0 && lz_q[0].cyc < cyc) begin
            e = lz_q.pop_front();
            n_checks++; n_errors++;
            $display("FAIL lz_missed cyc=%0d: got no sample, want one at that cycle", e.cyc);
        end
        if (lz_q.size() > 0 && lz_q[0].cyc == cyc) begin
            e = lz_q.pop_front();
            check_entry(e, "lzb", lif.an, lif.seg, lif.dp, lif.frame_tick, lif.digit_idx);
        end
    end

    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_at(input int c, input logic [15:0] v, input logic [3:0] dpv,
                           input logic [3:0] bl);
        step_to(c);
        dif.load = 1'b1; dif.value = v; dif.dp_in = dpv; dif.blank_in = bl;
        step_to(c + 1);
        dif.load = 1'b0;
    endtask

    initial begin
        int b1, b2, b3;
        rst = 1'b1;
        dif.enable = 1'b0; dif.load = 1'b0; dif.value = '0; dif.dp_in = '0; dif.blank_in = '0;
        push_e(1, 4'hF, 7'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        push_e(2, 4'hF, 7'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step_to(2);
        rst = 1'b0; dif.enable = 1'b1; dif.load = 1'b1; dif.value = 16'h12AF;
        b1 = 3;
        // Scan of 12AF, tear-free switch to 0000, then dp/blank update.
        expect_run(b1, b1,      b1 + 33, G_12AF, 4'b1111, 4'b0000, 1'b0);
        expect_run(b1, b1 + 33, b1 + 65, G_0000, 4'b1111, 4'b0000, 1'b0);
        expect_run(b1, b1 + 65, b1 + 87, G_12AF, 4'b1110, 4'b0100, 1'b0);
        // Enable dropped while digit 1 is driven, then dark with idx back at 0.
        push_e(b1 + 87, 4'b1101, 7'b1110111, 1'b0, 1'b0, 2'd0, 1'b0);
        for (int c = b1 + 88; c < b1 + 92; c++) push_e(c, 4'hF, 7'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step_to(b1);
        dif.load = 1'b0;
        load_at(b1 + 22, 16'h0000, 4'b0000, 4'b0000);
        load_at(b1 + 49, 16'h12AF, 4'b0100, 4'b0001);
        step_to(b1 + 86);
        dif.enable = 1'b0;
        load_at(b1 + 89, 16'h3456, 4'b0000, 4'b0000);
        step_to(b1 + 91);
        dif.enable = 1'b1;
        b2 = b1 + 92;
        expect_run(b2, b2, b2 + 12, G_3456, 4'b1111, 4'b0000, 1'b0);
        push_e(b2 + 12, 4'hF, 7'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step_to(b2 + 10);
        dif.load = 1'b1; dif.value = 16'hBEEF; dif.dp_in = 4'b1111; dif.blank_in = 4'b0000;
        step_to(b2 + 11);
        dif.load = 1'b0; rst = 1'b1;
        step_to(b2 + 12);
        rst = 1'b0;
        b3 = b2 + 13;
        // After reset the discarded BEEF must never show; then 0070 on both DUTs.
        expect_run(b3, b3,      b3 + 49, G_0000, 4'b1111, 4'b0000, 1'b0);
        expect_run(b3, b3 + 49, b3 + 65, G_0070, 4'b1111, 4'b0000, 1'b0);
        expect_run(b3, b3,      b3 + 49, G_0000, 4'b0001, 4'b0000, 1'b1);
        expect_run(b3, b3 + 49, b3 + 65, G_0070, 4'b0011, 4'b0000, 1'b1);
        load_at(b3 + 34, 16'h0070, 4'b0000, 4'b0000);
        step_to(b3 + 68);
        n_checks++;
        if (main_q.size() != 0 || lz_q.size() != 0) begin
            n_errors++;
            $display("FAIL drained: got %0d/%0d entries left, want 0/0", main_q.size(), lz_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by cycle %0d, want finish before it", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seven_seg_mux_driver.md
Name: seven_seg_mux_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode/cathode seven-segment display, successor to the single-digit hex decoder. It holds a double-buffered display value, scans one digit per refresh slot with a ghost-suppression guard interval, and supports per-digit decimal points, per-digit forced blanking and optional leading-zero blanking. It sits between the datapath (counter/result registers) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8); digit 0 is the least significant and rightmost.
REFRESH_DIV, 50000, clock cycles per digit slot (>= 2).
GUARD_CYCLES, 500, cycles at the start of each slot with all anodes off (0 <= GUARD_CYCLES < REFRESH_DIV).
SEG_ACTIVE_LOW, 0, 1 = segment/dp outputs are inverted at the pins.
AN_ACTIVE_LOW, 1, 1 = anode outputs are active-low.
LZ_BLANK, 0, 1 = leading-zero blanking is enabled.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = scan the display; 0 = display dark
load  in  1  single-cycle strobe that captures value/dp_in/blank_in into the shadow buffer
value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i
dp_in  in  NUM_DIGITS  decimal point per digit
blank_in  in  NUM_DIGITS  force digit dark
seg  out  7  segments a..g, with a as the MSB (seg[6]=a ... seg[0]=g)
dp  out  1  decimal point of the active digit
an  out  NUM_DIGITS  one-hot digit select (polarity per AN_ACTIVE_LOW)
digit_idx  out  clog2(NUM_DIGITS) (min 1)  index of the slot currently being scanned
frame_tick  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, idx=0, state=OFF, display and shadow registers=0, pending=0, an=all inactive, seg/dp=off (polarity applied), frame_tick=0. Reset has priority over every other input, and any pending load is discarded.
- Glyphs (active-high, a..g): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111.
- FSM states:
  - OFF: entered whenever enable=0.
  - GUARD: cnt < GUARD_CYCLES.
  - DRIVE: GUARD_CYCLES <= cnt <= REFRESH_DIV-1.
  - OFF->GUARD: enable=1, with cnt=0 and idx=0.
  - Any state->OFF: enable=0. cnt and idx clear to 0.
- Slot counter: cnt increments every enabled cycle. At cnt=REFRESH_DIV-1, cnt wraps to 0 and idx advances modulo NUM_DIGITS.
- Frame wrap (idx NUM_DIGITS-1 -> 0): frame_tick=1 for exactly that cycle. If pending=1, the shadow buffer is copied to the display register and pending clears.
- Double buffer: load=1 copies the inputs into the shadow buffer and sets pending. While state=OFF, load writes the display register directly instead. A load in the same cycle as a wrap commits the new inputs at that wrap. Back-to-back loads keep the last one.
- Blanking: digit i is dark (seg and dp off, anode inactive) if blank_in_reg[i]=1. It is also dark if LZ_BLANK=1, i>0, and nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never leading-zero blanked.
- Outputs are registered with a fixed 1-cycle latency behind state:
  - an is active only for digit idx, only in DRIVE, and only if that digit is not dark.
  - seg/dp are off in OFF and GUARD.
  - digit_idx mirrors idx with no latency.
- NUM_DIGITS=1: idx stays 0 and frame_tick pulses every slot.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16 glyph constants;
  - the SEG_OFF constant;
  - the state enum (OFF, GUARD, DRIVE);
  - function hex_to_seg (nibble -> 7-bit active-high pattern).
- Sub-module seg7_glyph_rom: combinational nibble -> segment decode, instantiated once on the muxed nibble.
- The top level owns the counters, FSM, buffers, blanking logic and polarity inversion.

Test Plan:
Unless stated, the bench uses NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1, AN_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0, LZ_BLANK=0.
1. Reset then scan: rst high 2 cycles, then enable=1 and load value=16'h12AF. At the first DRIVE of each slot: an=1110 with seg=1000111 (F), then an=1101 with seg=1110111 (A), then an=1011 with seg=1101101 (2), then an=0111 with seg=0110000 (1). Each slot is 4 cycles with an=1111 for the first cycle. frame_tick pulses every 16 cycles.
2. Tear-free update: load value=16'h0000 mid-frame. The current frame completes with the old digits, and the new value appears only after the next frame_tick.
3. Leading-zero blanking (LZ_BLANK=1): value=16'h0070. Digits 3 and 2 keep an=1111 during their slots. Digit 1 shows 1110000. Digit 0 shows 1111110.
4. dp_in=4'b0100 and blank_in=4'b0001: dp=1 only in the digit-2 slot, and digit 0 stays dark for its whole slot.
5. enable dropped mid-slot: one cycle later an=1111, seg=0000000, dp=0. On re-enable, scanning restarts at idx=0 with a GUARD cycle first.
6. rst asserted mid-DRIVE with a load pending: the next edge gives idx=0, an=1111 and a display register of 0. The pending value never appears.
